// File: rtl/alu_issue_stage_pkg.sv
// Shared widths, register-0 constant and pipeline bundles
// for the ALU issue/writeback stage.
package alu_issue_stage_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 6;
    localparam int REG_NUM = 2 ** ADDR_W;
    localparam int OP_W    = 4;

    localparam logic [ADDR_W-1:0] R0_ADDR = '0;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
    } id_ex_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              ovf;
    } ex_wb_t;

endpackage

// File: rtl/alu_regfile.sv
// 64x32 register file: two read ports, one write port,
// one debug read port; R0 always reads zero.
module alu_regfile
    import alu_issue_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [REG_NUM];

    // Storage array; writes to R0 are silently dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr != R0_ADDR) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd1_data = (rd1_addr == R0_ADDR) ? '0 : mem[rd1_addr];
    assign rd2_data = (rd2_addr == R0_ADDR) ? '0 : mem[rd2_addr];
    assign dbg_data = (dbg_addr == R0_ADDR) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand fetch, issue and writeback around an external
// combinational ALU, with full EX/WB forwarding.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [OP_W-1:0]   inst_op,
    input  logic [ADDR_W-1:0] inst_rd,
    input  logic [ADDR_W-1:0] inst_rs1,
    input  logic [ADDR_W-1:0] inst_rs2,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              alu_enable,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_overflow,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_ovf,
    output logic              ovf_sticky,
    input  logic              ovf_clr,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    id_ex_t ex_q;
    ex_wb_t wb_q;

    logic              inst_fire;
    logic              ld_fire;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rs1;
    logic [DATA_W-1:0] rf_rs2;
    logic [DATA_W-1:0] src1_byp;
    logic [DATA_W-1:0] src2_byp;
    logic              ex_hit1;
    logic              ex_hit2;
    logic              wb_hit1;
    logic              wb_hit2;

    // Loads only slip in when nothing is offered or in flight.
    assign ld_ready   = !inst_valid && !ex_q.valid && !wb_q.valid;
    assign inst_ready = !ld_valid || !ld_ready;
    assign inst_fire  = inst_valid && inst_ready;
    assign ld_fire    = ld_valid && ld_ready;

    // WB and load never coincide, so WB simply takes the port.
    assign rf_we    = wb_q.valid || ld_fire;
    assign rf_waddr = wb_q.valid ? wb_q.rd   : ld_addr;
    assign rf_wdata = wb_q.valid ? wb_q.data : ld_data;

    alu_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .rd1_addr (inst_rs1),
        .rd1_data (rf_rs1),
        .rd2_addr (inst_rs2),
        .rd2_data (rf_rs2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // A producer targeting R0 must never forward.
    assign ex_hit1 = ex_q.valid && ex_q.rd != R0_ADDR
                     && ex_q.rd == inst_rs1;
    assign ex_hit2 = ex_q.valid && ex_q.rd != R0_ADDR
                     && ex_q.rd == inst_rs2;
    assign wb_hit1 = wb_q.valid && wb_q.rd != R0_ADDR
                     && wb_q.rd == inst_rs1;
    assign wb_hit2 = wb_q.valid && wb_q.rd != R0_ADDR
                     && wb_q.rd == inst_rs2;

    // Operand select: youngest producer (EX) beats WB beats regfile.
    always_comb begin
        src1_byp = rf_rs1;
        src2_byp = rf_rs2;
        if (ex_hit1) begin
            src1_byp = alu_out;
        end else if (wb_hit1) begin
            src1_byp = wb_q.data;
        end
        if (ex_hit2) begin
            src2_byp = alu_out;
        end else if (wb_hit2) begin
            src2_byp = wb_q.data;
        end
    end

    // EX register; payload holds when no instruction is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q.valid <= inst_fire;
            if (inst_fire) begin
                ex_q.op   <= inst_op;
                ex_q.rd   <= inst_rd;
                ex_q.src1 <= src1_byp;
                ex_q.src2 <= src2_byp;
            end
        end
    end

    // WB register captures the ALU result of a valid EX slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else begin
            wb_q.valid <= ex_q.valid;
            if (ex_q.valid) begin
                wb_q.rd   <= ex_q.rd;
                wb_q.data <= alu_out;
                wb_q.ovf  <= alu_overflow;
            end
        end
    end

    // Sticky overflow; a retiring overflow beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (wb_q.valid && wb_q.ovf) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

    assign alu_enable = ex_q.valid;
    assign alu_op     = ex_q.op;
    assign alu_src1   = ex_q.src1;
    assign alu_src2   = ex_q.src2;

    assign wb_valid = wb_q.valid;
    assign wb_rd    = wb_q.rd;
    assign wb_data  = wb_q.data;
    assign wb_ovf   = wb_q.ovf;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with an adder stub ALU and an
// in-order architectural reference model.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        inst_valid;
    logic        inst_ready;
    logic [3:0]  inst_op;
    logic [5:0]  inst_rd;
    logic [5:0]  inst_rs1;
    logic [5:0]  inst_rs2;
    logic        ld_valid;
    logic        ld_ready;
    logic [5:0]  ld_addr;
    logic [31:0] ld_data;
    logic        alu_enable;
    logic [3:0]  alu_op;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] alu_out;
    logic        alu_overflow;
    logic        wb_valid;
    logic [5:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ovf;
    logic        ovf_sticky;
    logic        ovf_clr;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_data;

    int errors = 0;
    int checks = 0;

    alu_issue_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst_op      (inst_op),
        .inst_rd      (inst_rd),
        .inst_rs1     (inst_rs1),
        .inst_rs2     (inst_rs2),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .alu_enable   (alu_enable),
        .alu_op       (alu_op),
        .alu_src1     (alu_src1),
        .alu_src2     (alu_src2),
        .alu_out      (alu_out),
        .alu_overflow (alu_overflow),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_ovf       (wb_ovf),
        .ovf_sticky   (ovf_sticky),
        .ovf_clr      (ovf_clr),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    // Stub ALU: add with signed overflow.
    assign alu_out      = alu_src1 + alu_src2;
    assign alu_overflow = (alu_src1[31] == alu_src2[31])
                          && (alu_out[31] != alu_src1[31]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference: arch = program-order values (updated at issue),
    // rf_m = committed regfile, ex_m/wb_m = what the ports show.
    typedef struct {
        bit          v;
        logic [3:0]  op;
        logic [5:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        bit          ovf;
    } slot_t;

    logic [31:0] arch [64];
    logic [31:0] rf_m [64];
    slot_t       ex_m;
    slot_t       wb_m;
    bit          sticky_m;

    task automatic clear_model();
        for (int i = 0; i < 64; i++) begin
            arch[i] = '0;
            rf_m[i] = '0;
        end
        ex_m     = '{default: '0};
        wb_m     = '{default: '0};
        sticky_m = 1'b0;
    endtask

    task automatic tick();
        bit ldr;
        bit ld_acc;
        bit acc;
        ldr    = !inst_valid && !ex_m.v && !wb_m.v;
        ld_acc = ld_valid && ldr && rst_n;
        acc    = inst_valid && (!ld_valid || !ldr) && rst_n;
        @(posedge clk);
        if (!rst_n) begin
            clear_model();
        end else begin
            if (wb_m.v && wb_m.ovf) sticky_m = 1'b1;
            else if (ovf_clr) sticky_m = 1'b0;
            if (wb_m.v && wb_m.rd != 0) rf_m[wb_m.rd] = wb_m.sum;
            if (ld_acc && ld_addr != 0) begin
                rf_m[ld_addr] = ld_data;
                arch[ld_addr] = ld_data;
            end
            if (ex_m.v) wb_m = ex_m;
            else wb_m.v = 1'b0;
            ex_m.v = 1'b0;
            if (acc) begin
                ex_m.v   = 1'b1;
                ex_m.op  = inst_op;
                ex_m.rd  = inst_rd;
                ex_m.a   = arch[inst_rs1];
                ex_m.b   = arch[inst_rs2];
                ex_m.sum = ex_m.a + ex_m.b;
                ex_m.ovf = (ex_m.a[31] == ex_m.b[31])
                           && (ex_m.sum[31] != ex_m.a[31]);
                if (inst_rd != 0) arch[inst_rd] = ex_m.sum;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        inst_valid = 1'b0;
        ld_valid   = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_load(input logic [5:0] a,
                           input logic [31:0] d);
        inst_valid = 1'b0;
        ld_valid   = 1'b1;
        ld_addr    = a;
        ld_data    = d;
        tick();
        ld_valid   = 1'b0;
    endtask

    task automatic drive_inst(input logic [5:0] rd,
                              input logic [5:0] rs1,
                              input logic [5:0] rs2);
        inst_valid = 1'b1;
        inst_op    = 4'($urandom);
        inst_rd    = rd;
        inst_rs1   = rs1;
        inst_rs2   = rs2;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({alu_enable, alu_op, alu_src1, alu_src2} !== '0) begin
            errors++;
            $display("FAIL reset_alu: got en=%b op=%h s1=%h s2=%h expected all 0",
                     alu_enable, alu_op, alu_src1, alu_src2);
        end
        checks++;
        if ({wb_valid, wb_rd, wb_data, wb_ovf, ovf_sticky} !== '0) begin
            errors++;
            $display("FAIL reset_wb: got v=%b rd=%h d=%h o=%b s=%b expected all 0",
                     wb_valid, wb_rd, wb_data, wb_ovf, ovf_sticky);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_model();
    endtask

    task automatic test_basic();
        logic [3:0] op;
        idle(2);
        ld_valid = 1'b1;
        ld_addr  = 6'd1;
        ld_data  = 32'h0f0f0f0f;
        @(negedge clk);
        checks++;
        if (ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ld_ready: got %b expected 1", ld_ready);
        end
        tick();
        do_load(6'd2, 32'h00000001);
        drive_inst(6'd3, 6'd1, 6'd2);
        op = inst_op;
        @(negedge clk);
        checks++;
        if (inst_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_inst_ready: got %b expected 1", inst_ready);
        end
        tick();
        inst_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({alu_enable, alu_op, alu_src1, alu_src2}
            !== {1'b1, op, 32'h0f0f0f0f, 32'h1}) begin
            errors++;
            $display("FAIL basic_ex: got en=%b op=%h s1=%h s2=%h expected 1 %h 0f0f0f0f 00000001",
                     alu_enable, alu_op, alu_src1, alu_src2, op);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 6'd3, 32'h0f0f0f10}) begin
            errors++;
            $display("FAIL basic_wb: got v=%b rd=%0d d=%h expected 1 3 0f0f0f10",
                     wb_valid, wb_rd, wb_data);
        end
        tick();
        dbg_addr = 6'd3;
        @(negedge clk);
        checks++;
        if ({wb_valid, alu_enable} !== 2'b00) begin
            errors++;
            $display("FAIL basic_drain: got wb_valid=%b alu_enable=%b expected 0 0",
                     wb_valid, alu_enable);
        end
        checks++;
        if (dbg_data !== 32'h0f0f0f10) begin
            errors++;
            $display("FAIL basic_dbg: got %h expected 0f0f0f10", dbg_data);
        end
    endtask

    task automatic test_back_to_back();
        drive_inst(6'd4, 6'd3, 6'd3);
        tick();
        drive_inst(6'd5, 6'd4, 6'd1);
        tick();
        inst_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({alu_src1, alu_src2} !== {32'h1e1e1e20, 32'h0f0f0f0f}) begin
            errors++;
            $display("FAIL b2b_ex_bypass: got s1=%h s2=%h expected 1e1e1e20 0f0f0f0f",
                     alu_src1, alu_src2);
        end
        checks++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 6'd4, 32'h1e1e1e20}) begin
            errors++;
            $display("FAIL b2b_wb1: got v=%b rd=%0d d=%h expected 1 4 1e1e1e20",
                     wb_valid, wb_rd, wb_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 6'd5, 32'h2d2d2d2f}) begin
            errors++;
            $display("FAIL b2b_wb2: got v=%b rd=%0d d=%h expected 1 5 2d2d2d2f",
                     wb_valid, wb_rd, wb_data);
        end
        tick();
    endtask

    task automatic test_wb_bypass();
        drive_inst(6'd9, 6'd1, 6'd2);
        tick();
        inst_valid = 1'b0;
        tick();
        drive_inst(6'd10, 6'd2, 6'd9);
        tick();
        inst_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({alu_src1, alu_src2} !== {arch[2], 32'h0f0f0f10}) begin
            errors++;
            $display("FAIL wb_bypass_ex: got s1=%h s2=%h expected %h 0f0f0f10",
                     alu_src1, alu_src2, arch[2]);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({wb_rd, wb_data} !== {6'd10, 32'h0f0f0f11}) begin
            errors++;
            $display("FAIL wb_bypass_wb: got rd=%0d d=%h expected 10 0f0f0f11",
                     wb_rd, wb_data);
        end
        tick();
    endtask

    task automatic test_overflow();
        idle(2);
        do_load(6'd6, 32'h7fffffff);
        do_load(6'd7, 32'h00000001);
        drive_inst(6'd8, 6'd6, 6'd7);
        tick();
        inst_valid = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if ({wb_valid, wb_data, wb_ovf} !== {1'b1, 32'h80000000, 1'b1}) begin
            errors++;
            $display("FAIL ovf_wb: got v=%b d=%h o=%b expected 1 80000000 1",
                     wb_valid, wb_data, wb_ovf);
        end
        tick();
        @(negedge clk);
        checks++;
        if (ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky_set: got %b expected 1", ovf_sticky);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sticky_clr: got %b expected 0", ovf_sticky);
        end
        drive_inst(6'd8, 6'd6, 6'd7);
        tick();
        inst_valid = 1'b0;
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_beats_clr: got %b expected 1", ovf_sticky);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
    endtask

    task automatic test_r0();
        idle(2);
        do_load(6'd11, 32'd5);
        drive_inst(6'd0, 6'd11, 6'd11);
        tick();
        drive_inst(6'd12, 6'd0, 6'd11);
        tick();
        inst_valid = 1'b0;
        dbg_addr   = 6'd0;
        @(negedge clk);
        checks++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 6'd0, 32'd10}) begin
            errors++;
            $display("FAIL r0_wb: got v=%b rd=%0d d=%h expected 1 0 0000000a",
                     wb_valid, wb_rd, wb_data);
        end
        checks++;
        if ({alu_src1, alu_src2} !== {32'd0, 32'd5}) begin
            errors++;
            $display("FAIL r0_no_bypass: got s1=%h s2=%h expected 0 5",
                     alu_src1, alu_src2);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({dbg_data, wb_data} !== {32'd0, 32'd5}) begin
            errors++;
            $display("FAIL r0_dbg: got dbg=%h wb=%h expected 0 5",
                     dbg_data, wb_data);
        end
        tick();
    endtask

    task automatic test_load_block();
        idle(2);
        drive_inst(6'd13, 6'd1, 6'd2);
        tick();
        inst_valid = 1'b0;
        ld_valid   = 1'b1;
        ld_addr    = 6'd14;
        ld_data    = 32'h0000abcd;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({ld_ready, inst_ready} !== 2'b01) begin
                errors++;
                $display("FAIL ld_blocked_%0d: got ld_ready=%b inst_ready=%b expected 0 1",
                         c, ld_ready, inst_ready);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if ({ld_ready, inst_ready} !== 2'b10) begin
            errors++;
            $display("FAIL ld_open: got ld_ready=%b inst_ready=%b expected 1 0",
                     ld_ready, inst_ready);
        end
        tick();
        ld_valid = 1'b0;
        dbg_addr = 6'd14;
        @(negedge clk);
        checks++;
        if (dbg_data !== 32'h0000abcd) begin
            errors++;
            $display("FAIL ld_write: got %h expected 0000abcd", dbg_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        bit          ldr_e;
        idle(2);
        for (int r = 1; r < 16; r++) begin
            d = $urandom;
            if (r % 2 == 1) d = {1'b0, d[30:0]} | 32'h70000000;
            do_load(6'(r), d);
        end
        for (int c = 0; c < 600; c++) begin
            inst_valid = ($urandom_range(0, 3) != 0) && (c % 40 > 6);
            inst_op    = 4'($urandom);
            inst_rd    = 6'($urandom_range(0, 15));
            inst_rs1   = 6'($urandom_range(0, 15));
            inst_rs2   = 6'($urandom_range(0, 15));
            ld_valid   = ($urandom_range(0, 4) == 0);
            ld_addr    = 6'($urandom_range(0, 15));
            ld_data    = $urandom;
            ovf_clr    = ($urandom_range(0, 15) == 0);
            dbg_addr   = 6'($urandom);
            @(negedge clk);
            ldr_e = !inst_valid && !ex_m.v && !wb_m.v;
            checks++;
            if ({alu_enable, alu_op, alu_src1, alu_src2}
                !== {ex_m.v, ex_m.op, ex_m.a, ex_m.b}) begin
                errors++;
                $display("FAIL rnd_ex c=%0d: got %b %h %h %h expected %b %h %h %h",
                         c, alu_enable, alu_op, alu_src1, alu_src2,
                         ex_m.v, ex_m.op, ex_m.a, ex_m.b);
            end
            checks++;
            if ({wb_valid, wb_rd, wb_data, wb_ovf}
                !== {wb_m.v, wb_m.rd, wb_m.sum, wb_m.ovf}) begin
                errors++;
                $display("FAIL rnd_wb c=%0d: got %b %0d %h %b expected %b %0d %h %b",
                         c, wb_valid, wb_rd, wb_data, wb_ovf,
                         wb_m.v, wb_m.rd, wb_m.sum, wb_m.ovf);
            end
            checks++;
            if ({ovf_sticky, ld_ready, inst_ready}
                !== {sticky_m, ldr_e, !ld_valid || !ldr_e}) begin
                errors++;
                $display("FAIL rnd_ctl c=%0d: got sticky=%b ld_rdy=%b i_rdy=%b expected %b %b %b",
                         c, ovf_sticky, ld_ready, inst_ready,
                         sticky_m, ldr_e, !ld_valid || !ldr_e);
            end
            checks++;
            if (dbg_data !== rf_m[dbg_addr]) begin
                errors++;
                $display("FAIL rnd_dbg c=%0d: R%0d got %h expected %h",
                         c, dbg_addr, dbg_data, rf_m[dbg_addr]);
            end
            tick();
        end
        ovf_clr = 1'b0;
        idle(3);
    endtask

    task automatic test_reset_midflight();
        bit seen_wb;
        seen_wb = 1'b0;
        drive_inst(6'd15, 6'd1, 6'd2);
        tick();
        drive_inst(6'd16, 6'd15, 6'd15);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({alu_enable, alu_op, alu_src1, alu_src2} !== '0) begin
            errors++;
            $display("FAIL rst_mid_alu: got en=%b op=%h s1=%h s2=%h expected all 0",
                     alu_enable, alu_op, alu_src1, alu_src2);
        end
        checks++;
        if ({wb_valid, wb_rd, wb_data, wb_ovf, ovf_sticky} !== '0) begin
            errors++;
            $display("FAIL rst_mid_wb: got v=%b rd=%h d=%h o=%b s=%b expected all 0",
                     wb_valid, wb_rd, wb_data, wb_ovf, ovf_sticky);
        end
        tick();
        inst_valid = 1'b0;
        rst_n      = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (wb_valid !== 1'b0) seen_wb = 1'b1;
            tick();
        end
        checks++;
        if (seen_wb) begin
            errors++;
            $display("FAIL rst_mid_no_wb: got wb_valid=1 after reset expected 0");
        end
        for (int r = 0; r < 64; r++) begin
            dbg_addr = 6'(r);
            #1;
            checks++;
            if (dbg_data !== 32'd0) begin
                errors++;
                $display("FAIL rst_mid_dbg: R%0d got %h expected 0", r, dbg_data);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        inst_valid = 1'b0;
        inst_op    = '0;
        inst_rd    = '0;
        inst_rs1   = '0;
        inst_rs2   = '0;
        ld_valid   = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;
        ovf_clr    = 1'b0;
        dbg_addr   = '0;
        clear_model();
        test_reset();
        test_basic();
        test_back_to_back();
        test_wb_bypass();
        test_overflow();
        test_r0();
        test_load_block();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand-fetch/issue and writeback stage wrapped around the combinational ALU (alu_enable, alu_op, src1, src2 -> alu_out, alu_overflow).
- Holds the 64x32 register file. Accepts register-addressed instructions through a valid/ready handshake, reads operands with bypassing, and drives the ALU ports from an execute register.
- Captures the ALU result and writes it back.
- The ALU sits outside this block and connects via ports.

Parameters:
DATA_W, 32, operand/result width
ADDR_W, 6, register address width
REG_NUM, 64, number of registers (2**ADDR_W)
OP_W, 4, ALU opcode width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
inst_valid  in  1  instruction offered
inst_ready  out  1  instruction accepted when valid&ready
inst_op  in  OP_W  ALU opcode
inst_rd  in  ADDR_W  destination register
inst_rs1  in  ADDR_W  source 1 register
inst_rs2  in  ADDR_W  source 2 register
ld_valid  in  1  external register load request
ld_ready  out  1  load accepted when valid&ready
ld_addr  in  ADDR_W  load address
ld_data  in  DATA_W  load data
alu_enable  out  1  to ALU
alu_op  out  OP_W  to ALU
alu_src1  out  DATA_W  to ALU src1
alu_src2  out  DATA_W  to ALU src2
alu_out  in  DATA_W  from ALU
alu_overflow  in  1  from ALU
wb_valid  out  1  writeback occurring this cycle
wb_rd  out  ADDR_W  writeback address
wb_data  out  DATA_W  writeback data
wb_ovf  out  1  overflow of the retiring instruction
ovf_sticky  out  1  set on any retired overflow
ovf_clr  in  1  synchronous clear of ovf_sticky
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  DATA_W  regfile[dbg_addr], combinational, no bypass

Behaviour:

Reset (rst_n low, async):
- All registers clear to 0; EX and WB valid bits clear.
- Outputs: alu_enable=0, alu_op=0, alu_src1/2=0, wb_valid=0, wb_rd=0, wb_data=0, wb_ovf=0, ovf_sticky=0.
- Reset mid-operation discards in-flight instructions; no writeback occurs.

Pipeline (instruction accepted in cycle N):
- N (ID): read rs1/rs2 and capture into the EX register at the end of N.
- N+1 (EX): EX register drives alu_enable=1, alu_op, alu_src1, alu_src2. alu_out/alu_overflow are captured into the WB register at the end of N+1.
- N+2 (WB): wb_valid=1 with wb_rd/wb_data/wb_ovf. The regfile is written at the end of N+2.
- Throughput is one instruction per cycle.
- When EX is invalid, alu_enable=0 and the ALU operand outputs hold their previous values.

Operand bypass, per source, highest priority first:
1. EX valid and EX rd == rs: use alu_out.
2. WB valid and WB rd == rs: use wb_data.
3. Otherwise: regfile.
- No stalls on hazards.

Register 0:
- R0 reads as 0 everywhere: bypass never matches rd 0.
- Writes to R0 are dropped; wb_valid still pulses.

Load port:
- ld_ready = !inst_valid && !EX valid && !WB valid. Loads happen only when the pipeline is empty and idle.
- Accepted load writes regfile[ld_addr] at the end of the same cycle. The load does not assert wb_valid.
- inst_ready = !ld_valid || !ld_ready. Instructions win whenever any instruction is pending or in flight.

Overflow:
- The result is written back regardless of overflow.
- ovf_sticky sets at the end of a WB cycle with wb_ovf=1.
- When ovf_clr coincides with a setting WB, the set wins.

Regfile:
- One write port, written by WB or by load (mutually exclusive by construction).
- Two bypassed read ports plus the dbg port.
- Async reset to all zeros.

Decomposition:
- Shared package/header: DATA_W, ADDR_W, REG_NUM, OP_W, and the R0 address constant. Opcode values stay in the existing ALU define set.
- One sub-module, alu_regfile: 2R+1W+debug read, async active-low reset, R0 hard-wired to zero.
- Bypass and pipeline control stay in alu_issue_stage.

Test Plan:
The bench uses a stub ALU: alu_out = src1+src2, alu_overflow = signed overflow.
1. Load R1=0x0f0f0f0f, R2=0x00000001. Issue rd=3, rs1=1, rs2=2 -> EX cycle shows alu_src1=0x0f0f0f0f, alu_src2=0x1. Two cycles after accept: wb_valid=1, wb_rd=3, wb_data=0x0f0f0f10. Afterwards dbg_addr=3 reads 0x0f0f0f10.
2. Back-to-back chain R4=R3+R3, then R5=R4+R1, issued consecutively -> second instruction's EX shows alu_src1=0x1e1e1e20 (EX bypass). wb_data=0x2d2d2d2f.
3. Gap-of-one dependency: consumer issued two cycles after producer -> operand comes from the WB bypass. Results match the non-bypassed reference.
4. Load R6=0x7fffffff, R7=0x00000001. Issue R8=R6+R7 -> wb_data=0x80000000, wb_ovf=1, ovf_sticky=1. Pulse ovf_clr -> sticky 0. ovf_clr in the same cycle as an overflow WB -> sticky stays 1.
5. Issue rd=0 with operands 5+5 -> wb_valid=1, dbg read of R0 stays 0. A later read of rs1=0 yields 0 despite the in-flight rd=0.
6. Assert rst_n low while two instructions are in flight -> wb_valid never asserts, all outputs 0, dbg reads 0 for every register. ld_valid during an in-flight instruction -> ld_ready=0 until WB completes.
